// File: rtl/sipo_framed_if.sv
// sipo_framed_if -- handshake bundle for the framed serial-to-parallel block.
//   Serial side  : data_in, in_valid (to block), in_ready (from block)
//   Parallel side: data_out, out_valid, bit_count, parity_err (from block),
//                  out_ready (to block)
//   master : producer/consumer side (drives data_in, in_valid, out_ready)
//   slave  : the sipo_framed block itself
interface sipo_framed_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 2);

  logic             data_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    bit_count;
  logic             parity_err;

  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, bit_count, parity_err
  );

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, data_out, out_valid, bit_count, parity_err
  );
endinterface

// File: rtl/sipo_framed.sv
// sipo_framed -- serial-in parallel-out word assembler with valid/ready on
// both sides. A shift register collects the current frame while a separate
// holding register presents the previous word, so reception overlaps with a
// slow consumer.
//   clk   : single clock, rising edge
//   reset : synchronous, active high
//   bus   : sipo_framed_if.slave (serial in, parallel out, bit_count,
//           parity_err)
// Parameters: WIDTH (2..64) word length; MSB_FIRST=1 puts the first received
// bit in data_out[WIDTH-1], 0 puts it in data_out[0].
// Build option: define SIPO_PARITY_EN to append one even-parity bit to every
// frame and report its check on parity_err; otherwise parity_err is tied 0.
module sipo_framed #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  sipo_framed_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 2);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {COLLECT = 2'd0, PARITY = 2'd1, STALL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {COLLECT = 2'd0, STALL = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             oval_q, oval_d;

  logic             in_rdy, accept, hold_free, done, load;
  logic [WIDTH-1:0] shifted, word;

`ifdef SIPO_PARITY_EN
  // acc_q is the running XOR of every accepted bit of the frame, parity bit
  // included, so a zero result means the frame had even parity.
  logic acc_q, acc_d, perr_q, perr_d, perr_new;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    oval_d    = oval_q;
    done      = 1'b0;
    load      = 1'b0;
    word      = shift_q;
`ifdef SIPO_PARITY_EN
    acc_d     = acc_q;
    perr_d    = perr_q;
    perr_new  = acc_q;
`endif
    in_rdy    = (state_q != STALL);
    accept    = bus.in_valid && in_rdy;
    hold_free = !oval_q || bus.out_ready;
    shifted   = MSB_FIRST ? {shift_q[WIDTH-2:0], bus.data_in}
                          : {bus.data_in, shift_q[WIDTH-1:1]};

    // Consumer took the word; a load below overrides this to keep valid high.
    if (bus.out_ready) oval_d = 1'b0;

    case (state_q)
      COLLECT: if (accept) begin
        shift_d = shifted;
        cnt_d   = cnt_q + CW'(1);
`ifdef SIPO_PARITY_EN
        acc_d   = acc_q ^ bus.data_in;
        if (cnt_q == CW'(WIDTH - 1)) state_d = PARITY;
`else
        if (cnt_q == CW'(WIDTH - 1)) begin
          done = 1'b1;
          word = shifted;
        end
`endif
      end
`ifdef SIPO_PARITY_EN
      PARITY: if (accept) begin
        // Parity bit only feeds the check; the data word is already complete.
        cnt_d    = cnt_q + CW'(1);
        acc_d    = acc_q ^ bus.data_in;
        perr_new = acc_q ^ bus.data_in;
        done     = 1'b1;
      end
`endif
      // Stalled word sits in shift_q (and its parity result in acc_q) until
      // the holding register frees up.
      STALL:   load = bus.out_ready;
      default: state_d = COLLECT;
    endcase

    if (done) begin
      if (hold_free) load = 1'b1;
      else           state_d = STALL;
    end

    if (load) begin
      data_d  = word;
      oval_d  = 1'b1;
      cnt_d   = '0;
      shift_d = '0;
      state_d = COLLECT;
`ifdef SIPO_PARITY_EN
      perr_d  = perr_new;
      acc_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      oval_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
      acc_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      oval_q  <= oval_d;
`ifdef SIPO_PARITY_EN
      acc_q   <= acc_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.data_out  = data_q;
  assign bus.out_valid = oval_q;
  assign bus.bit_count = cnt_q;
`ifdef SIPO_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_sipo_framed.sv
// tb_sipo_framed -- directed bench for sipo_framed. Two instances share one
// serial stream: dut_m (MSB_FIRST=1) and dut_l (MSB_FIRST=0). Inputs change
// on the falling edge; outputs are sampled on the falling edge.
module tb_sipo_framed;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 2);
`ifdef SIPO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic din = 1'b0, ival = 1'b0, dir_rdy = 1'b0, rnd_rdy = 1'b0, rnd_on = 1'b0;
  int   n_cmp = 0, n_bad = 0, got_n = 0;
  logic [W-1:0] exp_q[$];

  sipo_framed_if #(.WIDTH(W)) if_m ();
  sipo_framed_if #(.WIDTH(W)) if_l ();

  assign if_m.data_in   = din;
  assign if_m.in_valid  = ival;
  assign if_m.out_ready = rnd_on ? rnd_rdy : dir_rdy;
  assign if_l.data_in   = din;
  assign if_l.in_valid  = ival;
  assign if_l.out_ready = rnd_on ? rnd_rdy : dir_rdy;

  sipo_framed #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(if_m));
  sipo_framed #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(if_l));

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  // Serial stream for one frame, sent from bit FL-1 down to bit 0.
  function automatic logic [FL-1:0] frame_bits(input logic [W-1:0] w);
`ifdef SIPO_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_bit(input logic b);
    int t;
    t = 0;
    din = b; ival = 1'b1;
    while (!if_m.in_ready && t < 200) begin @(negedge clk); t++; end
    if (!if_m.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_bit_timeout in_ready=%b required 1", if_m.in_ready);
    end
    @(posedge clk); @(negedge clk);
    ival = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w);
    logic [FL-1:0] s;
    s = frame_bits(w);
    for (int i = FL - 1; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic test_reset;
    reset = 1'b1; dir_rdy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (if_m.data_out !== 8'h00) begin n_bad++; $display("FAIL rst_data got=%h exp=00", if_m.data_out); end
    n_cmp++; if (if_m.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", if_m.out_valid); end
    n_cmp++; if (if_m.bit_count !== CW'(0)) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", if_m.bit_count); end
    n_cmp++; if (if_m.parity_err !== 1'b0) begin n_bad++; $display("FAIL rst_perr got=%b exp=0", if_m.parity_err); end
    n_cmp++; if (if_m.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=1", if_m.in_ready); end
  endtask

  task automatic test_bit_order;
    logic [FL-1:0] s;
    dir_rdy = 1'b1;
    s = frame_bits(8'hB2);  // stream 1,0,1,1,0,0,1,0
    for (int i = FL - 1; i >= 0; i--) begin
      send_bit(s[i]);
      if (i == FL - 3) begin
        n_cmp++; if (if_m.bit_count !== CW'(3)) begin n_bad++; $display("FAIL mid_count got=%0d exp=3", if_m.bit_count); end
      end
    end
    n_cmp++; if (if_m.out_valid !== 1'b1) begin n_bad++; $display("FAIL order_valid got=%b exp=1", if_m.out_valid); end
    n_cmp++; if (if_m.data_out !== 8'hB2) begin n_bad++; $display("FAIL msb_first got=%h exp=b2", if_m.data_out); end
    n_cmp++; if (if_l.data_out !== 8'h4D) begin n_bad++; $display("FAIL lsb_first got=%h exp=4d", if_l.data_out); end
    n_cmp++; if (if_m.bit_count !== CW'(0)) begin n_bad++; $display("FAIL order_count got=%0d exp=0", if_m.bit_count); end
    @(negedge clk);
    n_cmp++; if (if_m.out_valid !== 1'b0) begin n_bad++; $display("FAIL order_valid_pulse got=%b exp=0", if_m.out_valid); end
    n_cmp++; if (if_m.data_out !== 8'hB2) begin n_bad++; $display("FAIL order_data_hold got=%h exp=b2", if_m.data_out); end
  endtask

  task automatic test_stall;
    dir_rdy = 1'b0;
    send_frame(8'hA5);
    n_cmp++; if (if_m.out_valid !== 1'b1 || if_m.data_out !== 8'hA5) begin n_bad++; $display("FAIL stall_first got=%b/%h exp=1/a5", if_m.out_valid, if_m.data_out); end
    send_frame(8'h3C);
    n_cmp++; if (if_m.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got=%b exp=0", if_m.in_ready); end
    n_cmp++; if (if_m.out_valid !== 1'b1 || if_m.data_out !== 8'hA5) begin n_bad++; $display("FAIL stall_hold got=%b/%h exp=1/a5", if_m.out_valid, if_m.data_out); end
    n_cmp++; if (if_l.data_out !== rev(8'hA5)) begin n_bad++; $display("FAIL stall_hold_l got=%h exp=%h", if_l.data_out, rev(8'hA5)); end
    n_cmp++; if (if_m.bit_count !== CW'(FL)) begin n_bad++; $display("FAIL stall_count got=%0d exp=%0d", if_m.bit_count, FL); end
    repeat (3) @(negedge clk);
    n_cmp++; if (if_m.in_ready !== 1'b0 || if_m.data_out !== 8'hA5) begin n_bad++; $display("FAIL stall_wait got=%b/%h exp=0/a5", if_m.in_ready, if_m.data_out); end
    dir_rdy = 1'b1;
    @(negedge clk);
    dir_rdy = 1'b0;
    n_cmp++; if (if_m.out_valid !== 1'b1 || if_m.data_out !== 8'h3C) begin n_bad++; $display("FAIL stall_release got=%b/%h exp=1/3c", if_m.out_valid, if_m.data_out); end
    n_cmp++; if (if_m.in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready_back got=%b exp=1", if_m.in_ready); end
    n_cmp++; if (if_m.bit_count !== CW'(0)) begin n_bad++; $display("FAIL stall_count_clr got=%0d exp=0", if_m.bit_count); end
    dir_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (if_m.out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drain got=%b exp=0", if_m.out_valid); end
  endtask

  task automatic test_no_bubble;
    logic [FL-1:0] s;
    dir_rdy = 1'b0;
    send_frame(8'h5A);
    n_cmp++; if (if_m.out_valid !== 1'b1 || if_m.data_out !== 8'h5A) begin n_bad++; $display("FAIL b2b_first got=%b/%h exp=1/5a", if_m.out_valid, if_m.data_out); end
    s = frame_bits(8'hC3);
    for (int i = FL - 1; i >= 1; i--) send_bit(s[i]);
    dir_rdy = 1'b1;
    send_bit(s[0]);
    dir_rdy = 1'b0;
    n_cmp++; if (if_m.out_valid !== 1'b1 || if_m.data_out !== 8'hC3) begin n_bad++; $display("FAIL b2b_replace got=%b/%h exp=1/c3", if_m.out_valid, if_m.data_out); end
    n_cmp++; if (if_m.in_ready !== 1'b1 || if_m.bit_count !== CW'(0)) begin n_bad++; $display("FAIL b2b_ready got=%b/%0d exp=1/0", if_m.in_ready, if_m.bit_count); end
    dir_rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int seen;
    logic [W-1:0] got;
    logic [FL-1:0] s;
    seen = 0; got = '0;
    dir_rdy = 1'b1;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (if_m.bit_count !== CW'(0)) begin n_bad++; $display("FAIL mrst_count got=%0d exp=0", if_m.bit_count); end
    n_cmp++; if (if_m.out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got=%b exp=0", if_m.out_valid); end
    s = frame_bits(8'hFF);
    for (int i = FL - 1; i >= 0; i--) begin
      send_bit(s[i]);
      if (if_m.out_valid) begin seen++; got = if_m.data_out; end
    end
    @(negedge clk);
    if (if_m.out_valid) seen++;
    n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL mrst_words got=%0d exp=1", seen); end
    n_cmp++; if (got !== 8'hFF) begin n_bad++; $display("FAIL mrst_data got=%h exp=ff", got); end
  endtask

  task automatic test_parity;
    dir_rdy = 1'b1;
`ifdef SIPO_PARITY_EN
    for (int i = W - 1; i >= 0; i--) send_bit(((8'h07 >> i) & 8'h01) != 0);
    send_bit(1'b1);
    n_cmp++; if (if_m.parity_err !== 1'b0 || if_m.data_out !== 8'h07) begin n_bad++; $display("FAIL par_good got=%b/%h exp=0/07", if_m.parity_err, if_m.data_out); end
    for (int i = W - 1; i >= 0; i--) send_bit(((8'h07 >> i) & 8'h01) != 0);
    send_bit(1'b0);
    n_cmp++; if (if_m.parity_err !== 1'b1 || if_m.data_out !== 8'h07) begin n_bad++; $display("FAIL par_bad got=%b/%h exp=1/07", if_m.parity_err, if_m.data_out); end
    // parity_err follows the held word, not the shift register.
    @(negedge clk);
    n_cmp++; if (if_m.parity_err !== 1'b1) begin n_bad++; $display("FAIL par_hold got=%b exp=1", if_m.parity_err); end
`else
    send_frame(8'h07);
    n_cmp++; if (if_m.parity_err !== 1'b0 || if_m.data_out !== 8'h07) begin n_bad++; $display("FAIL par_tied got=%b/%h exp=0/07", if_m.parity_err, if_m.data_out); end
`endif
    repeat (2) @(negedge clk);
  endtask

  // Random consumer: picks out_ready each falling edge and checks any word
  // that will transfer at the next rising edge against the expected queue.
  always @(negedge clk) begin
    if (rnd_on) begin
      rnd_rdy = ($urandom_range(0, 3) != 0);
      if (if_m.out_valid && rnd_rdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rnd_extra got=%h exp=none", if_m.data_out);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          got_n++;
          if (if_m.data_out !== e || if_l.data_out !== rev(e) || if_m.parity_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd_word got=%h/%h/%b exp=%h/%h/0", if_m.data_out, if_l.data_out, if_m.parity_err, e, rev(e));
          end
        end
      end
    end
  end

  task automatic test_random;
    logic [W-1:0] w;
    logic [FL-1:0] s;
    int t;
    got_n = 0;
    rnd_on = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      w = W'($urandom);
      exp_q.push_back(w);
      s = frame_bits(w);
      for (int i = FL - 1; i >= 0; i--) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        send_bit(s[i]);
      end
    end
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    @(negedge clk);
    rnd_on = 1'b0;
    n_cmp++; if (got_n !== 1000 || exp_q.size() !== 0) begin n_bad++; $display("FAIL rnd_count got=%0d left=%0d exp=1000/0", got_n, exp_q.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bit_order();
    test_stall();
    test_no_bubble();
    test_mid_reset();
    test_parity();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
